// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encoding and execute-stage FSM states
package alu_pkg;

    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b1000,
        OP_SLL  = 4'b0001,
        OP_SLT  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SRA  = 4'b1101,
        OP_OR   = 4'b0110,
        OP_AND  = 4'b0111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } exec_state_e;

    // func_7 bit 6 only distinguishes ADD/SUB and SRL/SRA; elsewhere it is don't-care
    function automatic alu_op_e decode_op(input logic [3:0] code);
        alu_op_e op;
        op = OP_ADD;
        case (code[2:0])
            3'b000:  op = code[3] ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = code[3] ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - single-cycle add/sub/compare/logic datapath
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  y = a ^ b;
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_multicycle_exec.sv
// rtl/alu_multicycle_exec.sv - execute-stage ALU with serial shifter and valid/ready handshake
module alu_multicycle_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_controller,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = 1;

    exec_state_e        state;
    alu_op_e            op_in;
    alu_op_e            shift_op;
    logic [XLEN-1:0]    acc;
    logic [XLEN-1:0]    shifted;
    logic [XLEN-1:0]    core_y;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;
    logic               is_shift;

    assign op_in    = decode_op(alu_controller);
    assign shamt    = operand_b[SHAMT_W-1:0];
    assign is_shift = (op_in == OP_SLL) || (op_in == OP_SRL) || (op_in == OP_SRA);

    assign in_ready  = ((state == ST_IDLE) || ((state == ST_DONE) && out_ready)) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);

    alu_core #(.XLEN(XLEN)) u_core (
        .op (op_in),
        .a  (operand_a),
        .b  (operand_b),
        .y  (core_y)
    );

    always_comb begin
        case (shift_op)
            OP_SLL:  shifted = {acc[XLEN-2:0], 1'b0};
            OP_SRA:  shifted = {acc[XLEN-1], acc[XLEN-1:1]};
            default: shifted = {1'b0, acc[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            result   <= '0;
            acc      <= '0;
            cnt      <= '0;
            shift_op <= OP_ADD;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_SHIFT: begin
                    acc <= shifted;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        result <= shifted;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: if (out_ready) state <= ST_IDLE;
                default: ;
            endcase
            // an accept in DONE overrides the return to IDLE above
            if (accept) begin
                if (is_shift) begin
                    acc      <= operand_a;
                    shift_op <= op_in;
                    if (shamt == '0) begin
                        result <= operand_a;
                        state  <= ST_DONE;
                    end else begin
                        cnt   <= shamt;
                        state <= ST_SHIFT;
                    end
                end else begin
                    result <= core_y;
                    state  <= ST_DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle_exec.sv
// tb/tb_alu_multicycle_exec.sv - self-checking bench for alu_multicycle_exec
module tb_alu_multicycle_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_controller = 4'b0;
    logic [31:0] operand_a = 32'b0;
    logic [31:0] operand_b = 32'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    alu_multicycle_exec #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_controller (alu_controller),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = {27'b0, b[4:0]};
        case (c[2:0])
            3'd0:    return c[3] ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return c[3] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
        if (c[2:0] == 3'd1 || c[2:0] == 3'd5) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    // Behavioural model: pending result released after its latency, held until taken
    bit          m_valid = 1'b0;
    bit          m_busy = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_result = 32'b0;
    logic [31:0] m_pend = 32'b0;
    bit          m_take;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_busy = 1'b0; m_wait = 0; m_result = 32'b0;
        end else if (flush) begin
            m_valid = 1'b0; m_busy = 1'b0;
        end else begin
            m_take = in_valid && ((!m_busy && !m_valid) || (m_valid && out_ready));
            if (m_busy) begin
                m_wait--;
                if (m_wait == 0) begin m_busy = 1'b0; m_valid = 1'b1; m_result = m_pend; end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (m_take) begin
                if (ref_lat(alu_controller, operand_b) == 1) begin
                    m_valid = 1'b1;
                    m_result = ref_result(alu_controller, operand_a, operand_b);
                end else begin
                    m_busy = 1'b1; m_valid = 1'b0;
                    m_wait = ref_lat(alu_controller, operand_b) - 1;
                    m_pend = ref_result(alu_controller, operand_a, operand_b);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc in_ready", {31'b0, in_ready},
                {31'b0, ((!m_busy && !m_valid) || (m_valid && out_ready)) && !flush});
            chk("cyc out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            chk("cyc result", result, m_result);
        end
    end

    task automatic do_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int busy;
        bit got;
        alu_controller = c; operand_a = a; operand_b = b; in_valid = 1'b1; out_ready = 1'b1;
        got = 1'b0;
        for (int g = 0; g < 50 && !got; g++) begin
            @(negedge clk); got = in_ready;
            @(posedge clk); #1;
        end
        chk({nm, " accept"}, {31'b0, got}, 32'd1);
        in_valid = 1'b0;
        lat = 0; busy = 0; got = 1'b0;
        for (int g = 0; g < 100 && !got; g++) begin
            lat++;
            @(negedge clk);
            if (out_valid) got = 1'b1;
            else if (!in_ready) busy++;
        end
        chk({nm, " done"}, {31'b0, got}, 32'd1);
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " busy"}, busy, exp_lat - 1);
        chk({nm, " result"}, result, exp);
        @(posedge clk); #1;
    endtask

    bit seen;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        @(posedge clk); #1;

        do_op("add_wrap", 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1);
        do_op("sub", 4'b1000, 32'h0, 32'h1, 32'hFFFF_FFFF, 1);
        do_op("slt", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
        do_op("sltu", 4'b0011, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        do_op("and_1111", 4'b1111, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
        do_op("sra31", 4'b1101, 32'h8000_0000, 32'h0000_003F, 32'hFFFF_FFFF, 32);
        do_op("srl31", 4'b0101, 32'h8000_0000, 32'h0000_003F, 32'h1, 32);
        do_op("sll0", 4'b0001, 32'h1, 32'h0, 32'h1, 1);
        do_op("sll4", 4'b0001, 32'h0000_00A5, 32'h0000_0004, 32'h0000_0A50, 5);
        do_op("sra3_pos", 4'b1101, 32'h4000_0010, 32'h0000_0023, 32'h0800_0002, 4);
        do_op("or_1110", 4'b1110, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 1);

        // DONE held with out_ready low, then take-and-accept in one cycle
        alu_controller = 4'b0000; operand_a = 32'd10; operand_b = 32'd20;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold out_valid", {31'b0, out_valid}, 32'd1);
            chk("hold result", result, 32'd30);
            chk("hold in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1;
        alu_controller = 4'b0100; operand_a = 32'hFF; operand_b = 32'h0F;
        @(negedge clk);
        chk("take_accept in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("xor out_valid", {31'b0, out_valid}, 32'd1);
        chk("xor result", result, 32'h0000_00F0);
        @(posedge clk); #1;

        // back-to-back single-cycle ops
        for (int i = 0; i < 4; i++) begin
            alu_controller = 4'b0000; operand_a = 32'(i * 3); operand_b = 32'd100;
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            chk("b2b in_ready", {31'b0, in_ready}, 32'd1);
            if (i > 0) chk("b2b result", result, 32'((i - 1) * 3 + 100));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b last", result, 32'd109);
        @(posedge clk); #1;

        // flush on the third SHIFT cycle with a competing offer
        alu_controller = 4'b0001; operand_a = 32'h1; operand_b = 32'd10; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1;
        alu_controller = 4'b0000; operand_a = 32'd7; operand_b = 32'd8;
        @(negedge clk);
        chk("flush in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_flush in_ready", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("flush no out_valid", {31'b0, seen}, 32'd0);
        chk("flush result kept", result, 32'd109);
        @(posedge clk); #1;
        do_op("after_flush", 4'b0000, 32'd7, 32'd8, 32'd15, 1);

        // asynchronous reset in the middle of a shift
        alu_controller = 4'b0101; operand_a = 32'hFFFF_0000; operand_b = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async out_valid", {31'b0, out_valid}, 32'd0);
        chk("async result", result, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        do_op("add_after_reset", 4'b0000, 32'd2, 32'd3, 32'd5, 1);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
